dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Memory-side responder for the processor's data-memory port.
- Decodes each access from the processor:
  - low addresses pass through to the synchronous dmem RAM;
  - the top page hits memory-mapped registers: free-running cycle counter, transmit FIFO with status/overflow flags.
- The FIFO drains to a downstream consumer (UART/LED driver) over a valid/ready handshake.
- Reads return data with the same one-cycle latency as the RAM, so the processor sees a uniform memory.

Parameters:
- ADDR_WIDTH, 12, processor/RAM address width.
- DATA_WIDTH, 32, data word width.
- MMIO_BASE, 12'hF00, first MMIO address; addresses below it map to RAM.
- FIFO_DEPTH, 4, transmit FIFO entries (power of two, >=2).

Ports:
- clock, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- address_dmem, in, ADDR_WIDTH, processor access address.
- data, in, DATA_WIDTH, processor write data.
- wren, in, 1, processor write enable.
- q_dmem, out, DATA_WIDTH, read data to processor.
- ram_address, out, ADDR_WIDTH, RAM address (= address_dmem).
- ram_data, out, DATA_WIDTH, RAM write data (= data).
- ram_wren, out, 1, RAM write enable.
- ram_q, in, DATA_WIDTH, RAM read data, valid one cycle after address.
- tx_valid, out, 1, FIFO head valid.
- tx_data, out, DATA_WIDTH, FIFO head word.
- tx_ready, in, 1, consumer accepts head.

Behaviour:
- Decode:
  - ram_hit = address_dmem < MMIO_BASE.
  - ram_wren = wren & ram_hit, combinational; forced 0 while reset is low.
- MMIO map (offset from MMIO_BASE):
  - 0 CYCLE: reads counter; a write loads data.
  - 1 TXDATA: a write enqueues data; reads return 0.
  - 2 STATUS: read returns [0] empty, [1] full, [2] overflow (sticky), [7:4] count, remaining bits 0. A write with data[2]=1 clears overflow.
  - All other MMIO offsets: reads return 0, writes are ignored.
- Read latency:
  - The decode select and MMIO read value are registered on each edge.
  - q_dmem = ram_q when the registered select is RAM, otherwise the registered MMIO value.
  - Data therefore appears exactly one cycle after address, matching RAM.
  - A read of CYCLE returns the counter value sampled at the address edge.
- Cycle counter: increments by 1 every cycle, wraps 0xFFFFFFFF -> 0. A write at edge N makes the counter equal to data after N; no increment on that edge.
- FIFO:
  - Circular buffer with rd/wr pointers and count 0..FIFO_DEPTH.
  - push = wren & TXDATA hit. pop = tx_valid & tx_ready.
  - tx_valid = (count != 0); tx_data = entry at rd pointer; head is stable while tx_valid & !tx_ready.
  - push when count < FIFO_DEPTH: accepted.
  - push when full and pop in the same cycle: accepted, count unchanged.
  - push when full without pop: data dropped, overflow set to 1, pointers unchanged.
  - Simultaneous push and pop when not full: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: set by a dropped push; cleared only by a STATUS write with data[2]=1. If set and clear occur in the same cycle, set wins.
- Reset (reset low, asynchronous):
  - q_dmem=0, tx_valid=0, tx_data=0, counter=0, count=0, pointers=0, overflow=0, registered select = MMIO with value 0.
  - A reset mid-transaction discards FIFO contents; a handshake in progress is abandoned.
  - Normal operation resumes on the first rising edge after reset deasserts.

Test Plan:
- Reset/RAM passthrough:
  - Hold reset low, then release; write 0x12345678 to 0x010, then read 0x010.
  - Required: q_dmem=0 during reset; ram_wren=1 only on the write cycle; q_dmem=0x12345678 one cycle after the read address.
- Cycle counter:
  - Write 0xFFFFFFFE to 0xF00, then read it on the next cycle.
  - Required: read value 0xFFFFFFFF. A read two cycles after that returns 0x00000001, confirming wrap.
- FIFO fill and overflow:
  - tx_ready=0; write 0xA0..0xA4 to 0xF01 (5 writes).
  - Required: STATUS read = full=1, count=4, overflow=1; tx_data=0xA0.
  - Then set tx_ready=1: outputs 0xA0..0xA3 in order, then tx_valid=0 and empty=1.
- Full push plus pop:
  - With FIFO full and tx_ready=1, push 0xB0 in the same cycle.
  - Required: count stays 4, overflow not set, 0xB0 emerges after the remaining three entries.
- Overflow clear and unused MMIO:
  - Write 0x4 to 0xF02; read 0xF02 and 0xF07.
  - Required: overflow=0; 0xF07 reads 0; no RAM write occurs.
- Reset mid-drain:
  - Hold tx_ready=0 with 3 entries queued, then pulse reset low.
  - Required: tx_valid drops immediately (asynchronously); after release, count=0 and the counter restarts at 0.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder
// Memory-side responder for the processor data port. Low addresses pass
// straight through to a synchronous RAM. The top page holds a free-running
// cycle counter, a transmit FIFO, and its status register. Every read
// returns one cycle after its address, so RAM and MMIO look the same to
// the processor.
module dmem_mmio_responder #(
    parameter int                    ADDR_WIDTH = 12,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 12'hF00,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address_dmem,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q_dmem,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_CYCLE  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] OFF_TXDATA = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(2);

    // Address decode
    logic                  ram_hit;
    logic [ADDR_WIDTH-1:0] mmio_off;
    logic                  hit_cycle;
    logic                  hit_txdata;
    logic                  hit_status;

    assign ram_hit    = address_dmem < MMIO_BASE;
    assign mmio_off   = address_dmem - MMIO_BASE;
    assign hit_cycle  = !ram_hit && (mmio_off == OFF_CYCLE);
    assign hit_txdata = !ram_hit && (mmio_off == OFF_TXDATA);
    assign hit_status = !ram_hit && (mmio_off == OFF_STATUS);

    // The RAM sees the processor bus directly. Writes are gated off while
    // reset is held so that a reset cannot corrupt memory.
    assign ram_address = address_dmem;
    assign ram_data    = data;
    assign ram_wren    = wren & ram_hit & reset;

    // Transmit FIFO state
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  overflow;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic                  push_ok;
    logic                  push_drop;
    logic                  ovf_clr;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push       = wren & hit_txdata;
    assign pop        = tx_valid & tx_ready;
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign push_ok    = push & (!fifo_full | pop);
    assign push_drop  = push & fifo_full & !pop;
    assign ovf_clr    = wren & hit_status & data[2];

    assign tx_valid = !fifo_empty;
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : '0;

    // Cycle counter next value: a write loads the counter, otherwise it increments
    logic [DATA_WIDTH-1:0] cycle_cnt;
    logic [DATA_WIDTH-1:0] cycle_next;

    assign cycle_next = (wren & hit_cycle) ? data : cycle_cnt + 1'b1;

    // Status word and MMIO read mux. A CYCLE read returns the value the counter holds after the address edge.
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] mmio_rdata;

    always_comb begin
        // NOTE: every output gets a default first so that no path leaves it unassigned and infers a latch.
        status      = '0;
        status[0]   = fifo_empty;
        status[1]   = fifo_full;
        status[2]   = overflow;
        status[7:4] = 4'(fifo_count);
        mmio_rdata  = '0;
        if (hit_cycle) begin
            mmio_rdata = cycle_next;
        end else if (hit_status) begin
            mmio_rdata = status;
        end
    end

    // Register the decode select and MMIO read data to match RAM latency
    logic                  sel_ram_q;
    logic [DATA_WIDTH-1:0] mmio_q;

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sel_ram_q <= 1'b0;
            mmio_q    <= '0;
            cycle_cnt <= '0;
        end else begin
            sel_ram_q <= ram_hit;
            mmio_q    <= mmio_rdata;
            cycle_cnt <= cycle_next;
        end
    end

    assign q_dmem = sel_ram_q ? ram_q : mmio_q;

    // FIFO storage: the entries hold data only and are not part of the reset
    always_ff @(posedge clock) begin
        // NOTE: storage is not reset; the pointers and count make stale entries invisible.
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers, occupancy, and the sticky overflow flag (set wins over clear)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (pop && !push_ok) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Testbench for dmem_mmio_responder. It provides a synchronous RAM to sit
// behind the responder. A transaction-level model covers the rest: a word
// array, a queue for the FIFO, and an integer cycle counter.
module tb_dmem_mmio_responder;

    localparam int              AW    = 12;
    localparam int              DW    = 32;
    localparam int              DEPTH = 4;
    localparam logic [AW-1:0]   BASE  = 12'hF00;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] address_dmem;
    logic [DW-1:0] data;
    logic          wren;
    logic [DW-1:0] q_dmem;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic          tx_valid;
    logic [DW-1:0] tx_data;
    logic          tx_ready;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dmem_mmio_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MMIO_BASE(BASE), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .q_dmem(q_dmem), .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready)
    );

    // Synchronous RAM environment behind the responder
    logic [DW-1:0] ram_mem [0:4095];
    always @(posedge clock) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        ram_q <= ram_mem[ram_address];
    end

    // Reference model state
    logic [DW-1:0] m_ram [0:4095];
    logic [DW-1:0] m_fifo [$];
    logic [DW-1:0] m_cyc;
    bit            m_ovf;
    logic [DW-1:0] m_q;
    bit            m_q_valid;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_cyc     = '0;
        m_ovf     = 1'b0;
        m_q       = '0;
        m_q_valid = 1'b1;
    endtask

    function automatic logic [DW-1:0] model_status(input int sz);
        int st;
        st = (sz << 4) | (m_ovf ? 4 : 0) | ((sz == DEPTH) ? 2 : 0) | ((sz == 0) ? 1 : 0);
        return DW'(st);
    endfunction

    // One bus cycle: drive just after the falling edge, compare the DUT against the model,
    // advance the model across the rising edge, and return at the next falling edge.
    task automatic bus_cycle(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we, input bit rdy);
        int            sz;
        bit            rhit;
        bit            pop;
        bit            push;
        bit            drop;
        logic [DW-1:0] nxt_cyc;
        logic [DW-1:0] rd;
        address_dmem = a;
        data         = d;
        wren         = we;
        tx_ready     = rdy;
        #1;
        sz   = m_fifo.size();
        rhit = (a < BASE);
        if (m_q_valid) check("q_dmem", q_dmem, m_q);
        check("ram_wren", DW'(ram_wren), DW'(we && rhit));
        check("tx_valid", DW'(tx_valid), DW'(sz != 0));
        check("tx_data", tx_data, (sz != 0) ? m_fifo[0] : '0);

        pop     = (sz != 0) && rdy;
        push    = we && (a == BASE + 1);
        drop    = 1'b0;
        nxt_cyc = (we && a == BASE) ? d : m_cyc + 1;
        if (rhit)                rd = m_ram[a];
        else if (a == BASE)      rd = nxt_cyc;
        else if (a == BASE + 2)  rd = model_status(sz);
        else                     rd = '0;
        m_q       = rd;
        m_q_valid = !we;
        if (we && rhit) m_ram[a] = d;
        if (pop) void'(m_fifo.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) m_fifo.push_back(d);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (we && a == BASE + 2 && d[2]) m_ovf = 1'b0;
        m_cyc = nxt_cyc;
        @(negedge clock);
    endtask

    initial begin
        logic [DW-1:0] exp_order [4];
        logic [AW-1:0] ra;
        exp_order = '{32'hC1, 32'hC2, 32'hC3, 32'hB0};
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            m_ram[i]   = '0;
        end
        ram_q = '0;

        // Reset held with a RAM write pending on the bus: nothing may reach the RAM
        reset        = 1'b0;
        address_dmem = 12'h010;
        data         = 32'h12345678;
        wren         = 1'b1;
        tx_ready     = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_q_dmem", q_dmem, 32'h0);
        check("rst_ram_wren", DW'(ram_wren), 32'h0);
        check("rst_tx_valid", DW'(tx_valid), 32'h0);
        check("rst_tx_data", tx_data, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        model_reset();

        // RAM passthrough
        bus_cycle(12'h010, 32'h12345678, 1, 0);
        bus_cycle(12'h010, 32'h0, 0, 0);
        check("ram_readback", q_dmem, 32'h12345678);

        // Cycle counter load and wrap
        bus_cycle(BASE, 32'hFFFF_FFFE, 1, 0);
        bus_cycle(BASE, 32'h0, 0, 0);
        check("cyc_read", q_dmem, 32'hFFFF_FFFF);
        bus_cycle(12'h100, 32'h0, 0, 0);
        bus_cycle(BASE, 32'h0, 0, 0);
        check("cyc_wrap", q_dmem, 32'h0000_0001);

        // Fill past capacity, then drain
        for (int i = 0; i < 5; i++) bus_cycle(BASE + 1, 32'hA0 + i, 1, 0);
        bus_cycle(BASE + 2, 32'h0, 0, 0);
        check("status_full_ovf", q_dmem, 32'h46);
        check("head_a0", tx_data, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            check("drain_order", tx_data, 32'hA0 + i);
            bus_cycle(12'h020, 32'h0, 0, 1);
        end
        check("drained_valid", DW'(tx_valid), 32'h0);
        bus_cycle(BASE + 2, 32'h0, 0, 1);
        check("status_empty_ovf", q_dmem, 32'h05);

        // Overflow clear and an unused MMIO offset
        bus_cycle(BASE + 2, 32'h4, 1, 0);
        bus_cycle(BASE + 2, 32'h0, 0, 0);
        check("ovf_cleared", q_dmem, 32'h01);
        bus_cycle(BASE + 7, 32'hDEAD_BEEF, 1, 0);
        bus_cycle(BASE + 7, 32'h0, 0, 0);
        check("unused_reads_zero", q_dmem, 32'h0);

        // Push into a full FIFO while the head leaves
        for (int i = 0; i < 4; i++) bus_cycle(BASE + 1, 32'hC0 + i, 1, 0);
        bus_cycle(BASE + 1, 32'hB0, 1, 1);
        bus_cycle(BASE + 2, 32'h0, 0, 0);
        check("full_pushpop_status", q_dmem, 32'h42);
        for (int i = 0; i < 4; i++) begin
            check("pushpop_order", tx_data, exp_order[i]);
            bus_cycle(12'h020, 32'h0, 0, 1);
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            case ($urandom_range(0, 5))
                0, 1:    ra = AW'($urandom_range(0, 15));
                2:       ra = BASE;
                3:       ra = BASE + 1;
                4:       ra = BASE + 2;
                default: ra = BASE + AW'($urandom_range(3, 255));
            endcase
            bus_cycle(ra, $urandom, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0));
        end

        // Reset during a stalled drain
        for (int i = 0; i < 8 && m_fifo.size() != 0; i++) bus_cycle(12'h020, 32'h0, 0, 1);
        for (int i = 0; i < 3; i++) bus_cycle(BASE + 1, 32'hD0 + i, 1, 0);
        check("pre_rst_valid", DW'(tx_valid), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("rst_async_valid", DW'(tx_valid), 32'h0);
        check("rst_async_data", tx_data, 32'h0);
        check("rst_async_q", q_dmem, 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        bus_cycle(BASE, 32'h0, 0, 0);
        check("rst_cyc_restart", q_dmem, 32'h1);
        bus_cycle(BASE + 2, 32'h0, 0, 0);
        check("rst_status_empty", q_dmem, 32'h01);
        bus_cycle(12'h020, 32'h0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
